// File: rtl/point_plotter.sv
// Point plotter: clears the framebuffer on each frame start, then writes buffered points as lit pixels.
// Optional saturating drop/clip statistics are enabled with `define PLOT_STATS_EN.
module point_plotter #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8,
  parameter logic [PIX_W-1:0] PIX_ON = {PIX_W{1'b1}}
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             frame_start_in,
  input  logic [8:0]                       x_in,
  input  logic [7:0]                       y_in,
  input  logic                             valid_in,
  output logic [$clog2(H_RES*V_RES)-1:0]   bram_addr_out,
  output logic [PIX_W-1:0]                 bram_data_out,
  output logic                             bram_we_out,
  output logic                             busy_out,
  output logic                             clear_done_out,
  output logic [15:0]                      drop_count_out,
  output logic [15:0]                      clip_count_out
);

  localparam int NPIX   = H_RES * V_RES;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [31:0] H_LIM = 32'(H_RES);
  localparam logic [31:0] V_LIM = 32'(V_RES);
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic STATE_PLOT  = 1'b0;
  localparam logic STATE_CLEAR = 1'b1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  logic              on_screen, push_req, push, pop, fifo_full;
  logic [PTR_W-1:0]  push_idx;
  logic [ADDR_W-1:0] push_addr;

  assign on_screen = (32'(x_in) < H_LIM) && (32'(y_in) < V_LIM);
  assign push_req  = valid_in && on_screen;
  assign push_addr = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(x_in);
  assign fifo_full = (count_q == FIFO_FULL_CNT);

  // The bram_* registers hold the write for the next cycle; cnt_q is the next clear address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (frame_start_in) begin
      state_d = STATE_CLEAR;
      cnt_d   = ADDR_W'(1);
      we_d    = 1'b1;
      addr_d  = '0;
      data_d  = '0;
      busy_d  = 1'b1;
    end else if (state_q == STATE_CLEAR) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      data_d = '0;
      busy_d = 1'b1;
      if (cnt_q == LAST_ADDR) begin
        done_d  = 1'b1;
        state_d = STATE_PLOT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (count_q != '0) begin
      pop    = 1'b1;
      we_d   = 1'b1;
      addr_d = fifo_mem[rd_ptr_q];
      data_d = PIX_ON;
    end
  end

  // A frame start flushes the FIFO; a point arriving with it lands in the emptied FIFO.
  always_comb begin
    push     = push_req && (frame_start_in || !fifo_full || pop);
    push_idx = frame_start_in ? '0 : wr_ptr_q;
    rd_ptr_d = frame_start_in ? '0 : rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = push_idx + PTR_W'(push);
    count_d  = frame_start_in ? (PTR_W+1)'(push)
                              : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[push_idx] <= push_addr;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= STATE_PLOT;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bram_addr_out  = addr_q;
  assign bram_data_out  = data_q;
  assign bram_we_out    = we_q;
  assign busy_out       = busy_q;
  assign clear_done_out = done_q;

`ifdef PLOT_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic        drop_evt, clip_evt;

  assign drop_evt = push_req && !push;
  assign clip_evt = valid_in && !on_screen;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (clip_evt && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt_q <= '0;
      clip_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign drop_count_out = drop_cnt_q;
  assign clip_count_out = clip_cnt_q;
`else
  assign drop_count_out = 16'd0;
  assign clip_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_point_plotter.sv
// Directed bench for point_plotter: default 320x240, tiny 8x4 and wide 320x4 instances.
module tb_point_plotter;

`ifdef PLOT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0 = default instance, 1 = 8x4 instance, 2 = 320x4 instance
  logic       fs [3];
  logic [8:0] xs [3];
  logic [7:0] ys [3];
  logic       vs [3];

  logic [16:0] d_addr; logic [7:0] d_data; logic d_we, d_busy, d_done; logic [15:0] d_drop, d_clip;
  logic [4:0]  s_addr; logic [7:0] s_data; logic s_we, s_busy, s_done; logic [15:0] s_drop, s_clip;
  logic [10:0] w_addr; logic [7:0] w_data; logic w_we, w_busy, w_done; logic [15:0] w_drop, w_clip;

  int total = 0;
  int bad   = 0;

  point_plotter u_def (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fs[0]), .x_in(xs[0]), .y_in(ys[0]),
    .valid_in(vs[0]), .bram_addr_out(d_addr), .bram_data_out(d_data), .bram_we_out(d_we),
    .busy_out(d_busy), .clear_done_out(d_done), .drop_count_out(d_drop), .clip_count_out(d_clip));

  point_plotter #(.H_RES(8), .V_RES(4)) u_small (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fs[1]), .x_in(xs[1]), .y_in(ys[1]),
    .valid_in(vs[1]), .bram_addr_out(s_addr), .bram_data_out(s_data), .bram_we_out(s_we),
    .busy_out(s_busy), .clear_done_out(s_done), .drop_count_out(s_drop), .clip_count_out(s_clip));

  point_plotter #(.H_RES(320), .V_RES(4)) u_wide (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fs[2]), .x_in(xs[2]), .y_in(ys[2]),
    .valid_in(vs[2]), .bram_addr_out(w_addr), .bram_data_out(w_data), .bram_we_out(w_we),
    .busy_out(w_busy), .clear_done_out(w_done), .drop_count_out(w_drop), .clip_count_out(w_clip));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      fs[k] = 1'b0; vs[k] = 1'b0; xs[k] = '0; ys[k] = '0;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle_all();
    step(); step();
    rst = 1'b0;
    total++;
    if ({d_we, d_busy, d_done, d_addr, d_data, d_drop, d_clip} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs: got we=%0b addr=%0d, required all zero", d_we, d_addr);
    end
    fs[0] = 1'b1; step(); fs[0] = 1'b0;
    n = 0;
    while (d_addr !== 17'd1000 && n < 1100) begin step(); n++; end
    total++;
    if (d_addr !== 17'd1000 || d_busy !== 1'b1) begin
      bad++; $display("[TB] FAIL clear_reach_1000: got addr=%0d busy=%0b, required 1000 busy=1", d_addr, d_busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({d_we, d_busy, d_done, d_addr, d_data} !== '0) begin
      bad++; $display("[TB] FAIL async_reset: got we=%0b busy=%0b addr=%0d, required zero", d_we, d_busy, d_addr);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if ({d_we, d_busy, d_done, d_addr} !== '0) begin
      bad++; $display("[TB] FAIL post_reset_idle: got we=%0b busy=%0b addr=%0d, required zero", d_we, d_busy, d_addr);
    end
  endtask

  task automatic test_latency();
    xs[0] = 9'd5; ys[0] = 8'd2; vs[0] = 1'b1;
    step();
    vs[0] = 1'b0;
    total++;
    if (d_we !== 1'b0) begin
      bad++; $display("[TB] FAIL latency_n1: got we=%0b required 0", d_we);
    end
    step();
    total++;
    if (d_we !== 1'b1 || d_addr !== 17'd645 || d_data !== 8'hFF) begin
      bad++; $display("[TB] FAIL latency_n2: got we=%0b addr=%0d data=%h, required 1 645 ff", d_we, d_addr, d_data);
    end
    step();
    total++;
    if (d_we !== 1'b0 || d_addr !== 17'd645) begin
      bad++; $display("[TB] FAIL hold_addr: got we=%0b addr=%0d, required 0 645", d_we, d_addr);
    end
  endtask

  task automatic test_clip();
    xs[0] = 9'd320; ys[0] = 8'd10; vs[0] = 1'b1;
    step();
    xs[0] = 9'd0; ys[0] = 8'd240;
    step();
    vs[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (d_we !== 1'b0) begin
        bad++; $display("[TB] FAIL clip_no_write[%0d]: got we=%0b addr=%0d required we=0", i, d_we, d_addr);
      end
      step();
    end
    total++;
    if (d_clip !== (STATS ? 16'd2 : 16'd0) || d_drop !== 16'd0) begin
      bad++; $display("[TB] FAIL clip_count: got clip=%0d drop=%0d, required clip=%0d drop=0",
                      d_clip, d_drop, STATS ? 2 : 0);
    end
  endtask

  task automatic test_clear_small();
    fs[1] = 1'b1; step(); fs[1] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (s_we !== 1'b1 || s_addr !== 5'(i) || s_data !== 8'h00 || s_busy !== 1'b1 ||
          s_done !== (i == 31)) begin
        bad++; $display("[TB] FAIL clear_write[%0d]: got we=%0b addr=%0d data=%h busy=%0b done=%0b, required 1 %0d 00 1 %0b",
                        i, s_we, s_addr, s_data, s_busy, s_done, i, i == 31);
      end
      step();
    end
    total++;
    if (s_we !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_end: got we=%0b busy=%0b done=%0b, required 0 0 0", s_we, s_busy, s_done);
    end
  endtask

  task automatic test_drop();
    int n;
    fs[2] = 1'b1; step(); fs[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      xs[2] = 9'(10 + i); ys[2] = 8'(i % 4); vs[2] = 1'b1;
      step();
    end
    vs[2] = 1'b0;
    n = 0;
    while (w_done !== 1'b1 && n < 2000) begin step(); n++; end
    total++;
    if (w_done !== 1'b1 || w_addr !== 11'd1279) begin
      bad++; $display("[TB] FAIL drop_clear_done: got done=%0b addr=%0d, required 1 1279", w_done, w_addr);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (w_we !== 1'b1 || w_addr !== 11'((i % 4) * 320 + 10 + i) || w_data !== 8'hFF) begin
        bad++; $display("[TB] FAIL drain[%0d]: got we=%0b addr=%0d data=%h, required 1 %0d ff",
                        i, w_we, w_addr, w_data, (i % 4) * 320 + 10 + i);
      end
    end
    step();
    total++;
    if (w_we !== 1'b0 || w_drop !== (STATS ? 16'd4 : 16'd0)) begin
      bad++; $display("[TB] FAIL drop_count: got we=%0b drop=%0d, required we=0 drop=%0d",
                      w_we, w_drop, STATS ? 4 : 0);
    end
  endtask

  task automatic test_flush();
    int n;
    int writes;
    fs[2] = 1'b1; step(); fs[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xs[2] = 9'(50 + i); ys[2] = 8'd2; vs[2] = 1'b1;
      step();
    end
    fs[2] = 1'b1; xs[2] = 9'd1; ys[2] = 8'd1; vs[2] = 1'b1;
    step();
    fs[2] = 1'b0; vs[2] = 1'b0;
    total++;
    if (w_we !== 1'b1 || w_addr !== 11'd0 || w_data !== 8'h00 || w_busy !== 1'b1) begin
      bad++; $display("[TB] FAIL restart_clear: got we=%0b addr=%0d data=%h busy=%0b, required 1 0 00 1",
                      w_we, w_addr, w_data, w_busy);
    end
    n = 0;
    while (w_done !== 1'b1 && n < 2000) begin step(); n++; end
    total++;
    if (w_done !== 1'b1) begin
      bad++; $display("[TB] FAIL flush_clear_done: got done=%0b required 1", w_done);
    end
    step();
    total++;
    if (w_we !== 1'b1 || w_addr !== 11'd321 || w_data !== 8'hFF) begin
      bad++; $display("[TB] FAIL flush_point: got we=%0b addr=%0d data=%h, required 1 321 ff", w_we, w_addr, w_data);
    end
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (w_we === 1'b1) writes++;
    end
    total++;
    if (writes !== 0 || w_drop !== (STATS ? 16'd4 : 16'd0)) begin
      bad++; $display("[TB] FAIL flush_extra: got writes=%0d drop=%0d, required 0 and %0d",
                      writes, w_drop, STATS ? 4 : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_latency();
    test_clip();
    test_clear_small();
    test_drop();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
